gmm_param_update: RTL and testbench

//   Per-pixel GMM parameter update; consumes out_rho/done_rho of the rho stage.

---
 rtl/gmm_param_update_pkg.sv | 83 ++++++++
 rtl/gmm_param_update_opseq.sv | 44 ++++
 rtl/gmm_param_update.sv | 141 ++++++++++++++
 tb/tb_gmm_param_update.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gmm_param_update_pkg.sv
// Shared definitions for the GMM parameter update: FP constants, FSM states,
// operator select and single-precision add/multiply helpers (RNE, subnormals flushed).
package gmm_param_update_pkg;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] VAR_MIN_DEF = 32'h4080_0000;  // 4.0

  typedef enum logic [3:0] {
    S_IDLE, S_SUB_D, S_MUL_RD, S_ADD_MU, S_MUL_DD,
    S_SUB_V, S_MUL_RE, S_ADD_V, S_CLAMP, S_DONE
  } state_e;

  typedef enum logic {OP_ADD, OP_MUL} op_e;

  // a - b is issued as a + fp_neg(b)
  function automatic logic [31:0] fp_neg(input logic [31:0] x);
    return {~x[31], x[30:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l, s;
    logic [8:0]  diff;
    logic [50:0] ml, ms, sum, nrm;
    logic [5:0]  lz;
    logic [24:0] m;
    logic signed [9:0] e;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
        return FP_QNAN;
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return FP_QNAN;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    // larger magnitude first so the difference is never negative
    if (a[30:0] >= b[30:0]) begin l = a; s = b; end
    else                    begin l = b; s = a; end
    diff = {1'b0, l[30:23]} - {1'b0, s[30:23]};
    ml   = {2'b01, l[22:0], 26'd0};
    // beyond 26 places the small operand only matters as a sticky bit
    ms   = (diff > 9'd26) ? 51'd1 : ({2'b01, s[22:0], 26'd0} >> diff);
    sum  = (l[31] == s[31]) ? ml + ms : ml - ms;
    if (sum == 51'd0) return FP_ZERO;
    lz = 6'd0;
    for (int i = 0; i < 51; i++) if (sum[i]) lz = 6'(50 - i);
    nrm = sum << lz;
    e   = $signed({2'b00, l[30:23]}) + 10'sd1 - $signed({4'b0000, lz});
    m   = {1'b0, nrm[50:27]} + 25'(nrm[26] & ((|nrm[25:0]) | nrm[27]));
    if (m[24]) begin e = e + 10'sd1; m = m >> 1; end
    if (e >= 10'sd255) return {l[31], 8'hFF, 23'd0};
    if (e <= 10'sd0)   return {l[31], 31'd0};
    return {l[31], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sg, az, bz, ai, bi, g, st;
    logic [47:0] p;
    logic [24:0] m;
    logic signed [9:0] e;
    sg = a[31] ^ b[31];
    az = (a[30:23] == 8'd0);
    bz = (b[30:23] == 8'd0);
    ai = (a[30:23] == 8'hFF);
    bi = (b[30:23] == 8'hFF);
    if ((ai && a[22:0] != 23'd0) || (bi && b[22:0] != 23'd0)) return FP_QNAN;
    if ((ai && bz) || (bi && az)) return FP_QNAN;
    if (ai || bi) return {sg, 8'hFF, 23'd0};
    if (az || bz) return {sg, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1; end
    else       begin m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0]; end
    m = m + 25'(g & (st | m[0]));
    if (m[24]) begin e = e + 10'sd1; m = m >> 1; end
    if (e >= 10'sd255) return {sg, 8'hFF, 23'd0};
    if (e <= 10'sd0)   return {sg, 31'd0};
    return {sg, e[7:0], m[22:0]};
  endfunction

endpackage

// File: rtl/gmm_param_update_opseq.sv
// One FP adder and one FP multiplier behind a single start/done interface.
// Each unit takes an input strobe, computes one cycle later and presents a
// one-cycle result strobe (result always acknowledged). start -> done = 2 cycles.
module gmm_param_update_opseq
  import gmm_param_update_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_start,
  input  op_e         i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [31:0] o_z
);

  logic        w_add_stb, w_mul_stb;
  logic        r_add_v, r_mul_v, r_done;
  logic [31:0] r_add_a, r_add_b, r_mul_a, r_mul_b, r_z;

  assign w_add_stb = i_start & (i_op == OP_ADD);
  assign w_mul_stb = i_start & (i_op == OP_MUL);

  // operand capture on the input strobes, then result register with output strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_add_v <= 1'b0; r_mul_v <= 1'b0; r_done <= 1'b0;
      r_add_a <= '0;   r_add_b <= '0;
      r_mul_a <= '0;   r_mul_b <= '0;   r_z <= '0;
    end else begin
      r_add_v <= w_add_stb;
      r_mul_v <= w_mul_stb;
      if (w_add_stb) begin r_add_a <= i_a; r_add_b <= i_b; end
      if (w_mul_stb) begin r_mul_a <= i_a; r_mul_b <= i_b; end
      r_done <= r_add_v | r_mul_v;
      if (r_add_v)      r_z <= fp_add(r_add_a, r_add_b);
      else if (r_mul_v) r_z <= fp_mul(r_mul_a, r_mul_b);
    end
  end

  assign o_done = r_done;
  assign o_z    = r_z;

endmodule

// File: rtl/gmm_param_update.sv
// GMM per-pixel parameter update: mu' = mu + rho*(grey-mu),
// var' = var + rho*((grey-mu)^2 - var), sequenced over one shared FP add/mul pair.
// Optional variance floor: define GMM_VAR_FLOOR_EN to add a CLAMP state that
// forces var_o to VAR_MIN when var' is negative or smaller than VAR_MIN.
module gmm_param_update
  import gmm_param_update_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] VAR_MIN = VAR_MIN_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_upd,
  input  logic [WIDTH-1:0] rho,
  input  logic [WIDTH-1:0] grey,
  input  logic [WIDTH-1:0] mugrey,
  input  logic [WIDTH-1:0] var_i,
  output logic [WIDTH-1:0] mu_o,
  output logic [WIDTH-1:0] var_o,
  output logic             busy_o,
  output logic             done_upd
);

  if (WIDTH != 32 || VAR_MIN[31]) begin : g_cfg_chk
    $error("gmm_param_update: WIDTH must be 32 and VAR_MIN positive");
  end

  state_e           r_state, w_next;
  logic [WIDTH-1:0] r_rho, r_grey, r_mu, r_var;
  logic [WIDTH-1:0] r_d, r_rd, r_mu_n, r_d2, r_e, r_re, r_var_n;
  logic [WIDTH-1:0] r_mu_o, r_var_o;
  logic             r_issued;
  logic             w_is_op, w_start, w_done;
  op_e              w_op;
  logic [WIDTH-1:0] w_a, w_b, w_z;

  gmm_param_update_opseq u_opseq (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_start(w_start),
    .i_op   (w_op),
    .i_a    (w_a),
    .i_b    (w_b),
    .o_done (w_done),
    .o_z    (w_z)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next state: operator states advance only on the unit's result strobe
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (en_upd) w_next = S_SUB_D;
      S_SUB_D:  if (w_done) w_next = S_MUL_RD;
      S_MUL_RD: if (w_done) w_next = S_ADD_MU;
      S_ADD_MU: if (w_done) w_next = S_MUL_DD;
      S_MUL_DD: if (w_done) w_next = S_SUB_V;
      S_SUB_V:  if (w_done) w_next = S_MUL_RE;
      S_MUL_RE: if (w_done) w_next = S_ADD_V;
`ifdef GMM_VAR_FLOOR_EN
      S_ADD_V:  if (w_done) w_next = S_CLAMP;
      S_CLAMP:  w_next = S_DONE;
`else
      S_ADD_V:  if (w_done) w_next = S_DONE;
`endif
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // outputs: status flags, operator select and operands (stable for the whole state)
  always_comb begin
    busy_o   = (r_state != S_IDLE);
    done_upd = (r_state == S_DONE);
    w_op     = OP_ADD;
    w_a      = '0;
    w_b      = '0;
    w_is_op  = 1'b1;
    case (r_state)
      S_SUB_D:  begin w_a = r_grey; w_b = fp_neg(r_mu); end
      S_MUL_RD: begin w_op = OP_MUL; w_a = r_rho; w_b = r_d; end
      S_ADD_MU: begin w_a = r_mu; w_b = r_rd; end
      S_MUL_DD: begin w_op = OP_MUL; w_a = r_d; w_b = r_d; end
      S_SUB_V:  begin w_a = r_d2; w_b = fp_neg(r_var); end
      S_MUL_RE: begin w_op = OP_MUL; w_a = r_rho; w_b = r_e; end
      S_ADD_V:  begin w_a = r_var; w_b = r_re; end
      default:  w_is_op = 1'b0;
    endcase
    // strobe only on the entry cycle of each operator state
    w_start = w_is_op & ~r_issued;
  end

  // input capture, per-state temporaries and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rho <= '0; r_grey <= '0; r_mu <= '0; r_var <= '0;
      r_d <= '0; r_rd <= '0; r_mu_n <= '0; r_d2 <= '0;
      r_e <= '0; r_re <= '0; r_var_n <= '0;
      r_mu_o <= '0; r_var_o <= '0; r_issued <= 1'b0;
    end else begin
      if (r_state == S_IDLE && en_upd) begin
        r_rho <= rho; r_grey <= grey; r_mu <= mugrey; r_var <= var_i;
      end
      if (w_done)       r_issued <= 1'b0;
      else if (w_start) r_issued <= 1'b1;
      if (w_done) begin
        case (r_state)
          S_SUB_D:  r_d    <= w_z;
          S_MUL_RD: r_rd   <= w_z;
          S_ADD_MU: r_mu_n <= w_z;
          S_MUL_DD: r_d2   <= w_z;
          S_SUB_V:  r_e    <= w_z;
          S_MUL_RE: r_re   <= w_z;
          S_ADD_V: begin
            r_var_n <= w_z;
`ifndef GMM_VAR_FLOOR_EN
            r_mu_o  <= r_mu_n;
            r_var_o <= w_z;
`endif
          end
          default: ;
        endcase
      end
`ifdef GMM_VAR_FLOOR_EN
      if (r_state == S_CLAMP) begin
        r_mu_o  <= r_mu_n;
        r_var_o <= (r_var_n[31] || r_var_n[30:0] < VAR_MIN[30:0]) ? VAR_MIN : r_var_n;
      end
`endif
    end
  end

  assign mu_o  = r_mu_o;
  assign var_o = r_var_o;

endmodule

// File: tb/tb_gmm_param_update.sv
// Bench for gmm_param_update: a cycle-level model (real arithmetic rounded to
// single precision, a busy countdown) checked every cycle, plus directed literals.
module tb_gmm_param_update;

  localparam logic [31:0] VMIN = 32'h4080_0000;
`ifdef GMM_VAR_FLOOR_EN
  localparam int NBUSY = 23;  // cycles from the accept edge to the end of DONE
  localparam logic [31:0] C3_VAR = 32'h4080_0000;
`else
  localparam int NBUSY = 22;
  localparam logic [31:0] C3_VAR = 32'h0000_0000;
`endif

  logic        clk, rst, en_upd;
  logic [31:0] rho, grey, mugrey, var_i, mu_o, var_o;
  logic        busy_o, done_upd;

  int n_cmp = 0, n_err = 0;
  logic chk_en = 1'b0;

  gmm_param_update dut (
    .clk_i(clk), .rst_i(rst), .en_upd(en_upd), .rho(rho), .grey(grey),
    .mugrey(mugrey), .var_i(var_i), .mu_o(mu_o), .var_o(var_o),
    .busy_o(busy_o), .done_upd(done_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0)       d = {b[31], 63'd0};
    else if (b[30:23] == 8'hFF) d = {b[31], 11'h7FF, b[22:0], 29'd0};
    else                        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [22:0] m;
    logic        rnd;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, (d[51:0] != 52'd0) ? 23'h400000 : 23'd0};
    e   = int'(d[62:52]) - 896;
    m   = d[51:29];
    rnd = d[28] & ((|d[27:0]) | m[0]);
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], e[7:0], m} + 32'(rnd);
  endfunction

  // each step rounded to single precision, as the hardware does
  function automatic logic [63:0] model(input logic [31:0] r, g, m, v);
    logic [31:0] d, rd, mn, d2, e, re, vn;
    d  = r2f(f2r(g) - f2r(m));
    rd = r2f(f2r(r) * f2r(d));
    mn = r2f(f2r(m) + f2r(rd));
    d2 = r2f(f2r(d) * f2r(d));
    e  = r2f(f2r(d2) - f2r(v));
    re = r2f(f2r(r) * f2r(e));
    vn = r2f(f2r(v) + f2r(re));
`ifdef GMM_VAR_FLOOR_EN
    if (vn[31] || vn[30:0] < VMIN[30:0]) vn = VMIN;
`endif
    return {mn, vn};
  endfunction

  int          m_bcnt = 0;
  logic [31:0] m_mu = '0, m_var = '0;
  logic [63:0] m_pend = '0;

  // timing/value model: busy for NBUSY cycles after an accepted request
  always @(posedge clk) begin
    if (rst) begin
      m_bcnt <= 0; m_mu <= '0; m_var <= '0;
    end else if (m_bcnt > 0) begin
      m_bcnt <= m_bcnt - 1;
      if (m_bcnt == 2) begin m_mu <= m_pend[63:32]; m_var <= m_pend[31:0]; end
    end else if (en_upd) begin
      m_pend <= model(rho, grey, mugrey, var_i);
      m_bcnt <= NBUSY;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_o",   {31'd0, busy_o},   {31'd0, m_bcnt > 0});
      chk("done_upd", {31'd0, done_upd}, {31'd0, m_bcnt == 1});
      chk("mu_o",     mu_o,  m_mu);
      chk("var_o",    var_o, m_var);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [31:0] r, g, m, v);
    rho = r; grey = g; mugrey = m; var_i = v;
  endtask

  task automatic run(input string nm, input logic [31:0] r, g, m, v, emu, evar);
    int lat;
    @(negedge clk); set_in(r, g, m, v); en_upd = 1'b1;
    @(negedge clk); en_upd = 1'b0;
    lat = 1;
    while (done_upd !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    chk({nm, "_latency"}, 32'(lat), 32'(NBUSY));
    chk({nm, "_mu"}, mu_o, emu);
    chk({nm, "_var"}, var_o, evar);
    @(negedge clk);
  endtask

  task automatic count_dones(input int n, output int c);
    c = 0;
    repeat (n) begin @(negedge clk); if (done_upd) c++; end
  endtask

  initial begin
    logic [63:0] pv;
    logic [31:0] g_mu, g_var;
    int c;
    rst = 1'b1; en_upd = 1'b0; set_in('0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_mu", mu_o, 32'h0);
    chk("rst_var", var_o, 32'h0);
    chk("rst_busy", {31'd0, busy_o}, 32'h0);
    chk("rst_done", {31'd0, done_upd}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // pin the model to hand-derived values
    pv = model(32'h3F000000, 32'h42C80000, 32'h42A00000, 32'h41800000);
    chk("model_c1_mu", pv[63:32], 32'h42B40000);
    chk("model_c1_var", pv[31:0], 32'h43500000);
    pv = model(32'h3F800000, 32'h42480000, 32'h42480000, 32'h41800000);
    chk("model_c3_var", pv[31:0], C3_VAR);

    run("c1", 32'h3F000000, 32'h42C80000, 32'h42A00000, 32'h41800000, 32'h42B40000, 32'h43500000);
    run("c2", 32'h00000000, 32'h42C80000, 32'h42A00000, 32'h41800000, 32'h42A00000, 32'h41800000);
    run("c3", 32'h3F800000, 32'h42480000, 32'h42480000, 32'h41800000, 32'h42480000, C3_VAR);
    // rho=0.25 grey=5 mu=10 var=1 -> mu'=8.75 var'=7
    run("cx", 32'h3E800000, 32'h40A00000, 32'h41200000, 32'h3F800000, 32'h410C0000, 32'h40E00000);

    // requests while busy are dropped, inputs only sampled at acceptance
    @(negedge clk); set_in(32'h3F000000, 32'h42C80000, 32'h42A00000, 32'h41800000); en_upd = 1'b1;
    @(negedge clk); en_upd = 1'b0;
    c = 0; g_mu = '0; g_var = '0;
    for (int i = 1; i <= 40; i++) begin
      if (done_upd) begin c++; g_mu = mu_o; g_var = var_o; end
      en_upd = (i == 5 || i == 10 || i == 15);
      if (en_upd) set_in(32'h3F800000, 32'h0, 32'h44000000, 32'h0);
      @(negedge clk);
    end
    chk("busy_drop_count", 32'(c), 32'd1);
    chk("busy_drop_mu", g_mu, 32'h42B40000);
    chk("busy_drop_var", g_var, 32'h43500000);

    // synchronous reset during MUL_DD
    @(negedge clk); set_in(32'h3F000000, 32'h42C80000, 32'h42A00000, 32'h41800000); en_upd = 1'b1;
    @(negedge clk); en_upd = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_busy", {31'd0, busy_o}, 32'h0);
    chk("midrst_mu", mu_o, 32'h0);
    chk("midrst_var", var_o, 32'h0);
    count_dones(30, c);
    chk("midrst_no_done", 32'(c), 32'd0);
    run("c1_after_rst", 32'h3F000000, 32'h42C80000, 32'h42A00000, 32'h41800000, 32'h42B40000, 32'h43500000);

    // en_upd held high: one update every NBUSY+1 cycles
    @(negedge clk); set_in(32'h3F000000, 32'h42C80000, 32'h42A00000, 32'h41800000); en_upd = 1'b1;
    count_dones(3 * (NBUSY + 1), c);
    en_upd = 1'b0;
    chk("held_en_dones", 32'(c), 32'd3);
    chk("held_en_mu", mu_o, 32'h42B40000);
    chk("held_en_var", var_o, 32'h43500000);
    repeat (NBUSY + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
